// File: rtl/iob_keypad_scan_pkg.sv
// Shared encodings for the matrix-keypad scanner:
// debounce FSM states, frame results and parameter floors.
package iob_keypad_scan_pkg;

    localparam int SCAN_DIV_MIN = 4;
    localparam int DEBOUNCE_MIN = 1;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } deb_state_t;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_KEY   = 2'd1,
        FR_MULTI = 2'd2
    } frame_res_t;

    // Saturating count of low columns: 0, 1, or "2 or more".
    function automatic logic [1:0] sat_add2(
        input logic [1:0] a,
        input logic [1:0] b
    );
        if (a == 2'd0) return b;
        if (b == 2'd0) return a;
        return 2'd2;
    endfunction

endpackage

// File: rtl/iob_keypad_scanner.sv
// Row driver and column sampler: walks the rows, samples the
// synchronized columns once per row, and classifies each frame.
module iob_keypad_scanner
    import iob_keypad_scan_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int CODE_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [COLS-1:0]   col_i,
    output logic [ROWS-1:0]   row_o,
    output logic              o_frame_done,
    output frame_res_t        o_frame_result,
    output logic [CODE_W-1:0] o_frame_code
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);

    logic [COLS-1:0]   r_col_s1;
    logic [COLS-1:0]   r_col_s2;
    logic [DW-1:0]     r_dwell;
    logic [RW-1:0]     r_row;
    logic              r_run;
    logic [1:0]        r_acc_n;
    logic [CODE_W-1:0] r_acc_code;

    logic              w_sample;
    logic              w_last_row;
    logic [COLS-1:0]   w_low;
    logic [ROWS-1:0]   w_onehot;
    logic [CODE_W-1:0] w_row_base;
    logic [1:0]        w_row_n;
    logic [CODE_W-1:0] w_row_code;
    logic [1:0]        w_tot_n;
    logic [CODE_W-1:0] w_tot_code;

    assign w_sample   = enable && (r_dwell == DW'(SCAN_DIV - 1));
    assign w_last_row = (r_row == RW'(ROWS - 1));
    assign w_low      = ~r_col_s2;
    assign w_onehot   = ROWS'(1) << r_row;
    assign w_row_base = CODE_W'(r_row) * CODE_W'(COLS);

    // r_run keeps rows released during reset and the first enabled cycle
    assign row_o = (enable && r_run) ? ~w_onehot : '1;

    // Two-flop synchronizer on the asynchronous column lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_s1 <= '1;
            r_col_s2 <= '1;
        end else begin
            r_col_s1 <= col_i;
            r_col_s2 <= r_col_s1;
        end
    end

    // Dwell and row sequencing, parked at row 0 / dwell 0 while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dwell <= '0;
            r_row   <= '0;
            r_run   <= 1'b0;
        end else if (!enable) begin
            r_dwell <= '0;
            r_row   <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_sample) begin
                r_dwell <= '0;
                r_row   <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // Count low columns on the active row and remember the last one
    always_comb begin
        w_row_n    = 2'd0;
        w_row_code = '0;
        for (int c = 0; c < COLS; c++) begin
            if (w_low[c]) begin
                w_row_n    = sat_add2(w_row_n, 2'd1);
                w_row_code = w_row_base + CODE_W'(c);
            end
        end
    end

    assign w_tot_n    = sat_add2(r_acc_n, w_row_n);
    assign w_tot_code = (r_acc_n != 2'd0) ? r_acc_code : w_row_code;

    // Frame accumulator, restarted after the last row is sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_n    <= 2'd0;
            r_acc_code <= '0;
        end else if (!enable || (w_sample && w_last_row)) begin
            r_acc_n    <= 2'd0;
            r_acc_code <= '0;
        end else if (w_sample) begin
            r_acc_n    <= w_tot_n;
            r_acc_code <= w_tot_code;
        end
    end

    assign o_frame_done = w_sample && w_last_row;
    assign o_frame_code = w_tot_code;

    // Classify the finished frame from its low-bit count
    always_comb begin
        o_frame_result = FR_MULTI;
        case (w_tot_n)
            2'd0:    o_frame_result = FR_NONE;
            2'd1:    o_frame_result = FR_KEY;
            default: o_frame_result = FR_MULTI;
        endcase
    end

endmodule

// File: rtl/iob_keypad_scan.sv
// Keypad scanner top: frame debounce FSM, one-code-per-press
// valid/ack handshake and sticky overrun flag.
module iob_keypad_scan
    import iob_keypad_scan_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 8,
    parameter int CODE_W   = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ROWS-1:0]   row_o,
    input  logic [COLS-1:0]   col_i,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ack,
    output logic              key_down,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    if (SCAN_DIV < SCAN_DIV_MIN) begin : g_bad_scan_div
        $error("iob_keypad_scan: SCAN_DIV below minimum");
    end
    if (DEBOUNCE < DEBOUNCE_MIN) begin : g_bad_debounce
        $error("iob_keypad_scan: DEBOUNCE below minimum");
    end

    deb_state_t        r_state;
    deb_state_t        w_state_nx;
    logic [CODE_W-1:0] r_cand;
    logic [CODE_W-1:0] w_cand_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_confirm;
    logic              w_ovr_set;
    logic              r_valid;
    logic [CODE_W-1:0] r_code;
    logic              r_ovr;

    logic              w_frame_done;
    frame_res_t        w_fr_res;
    logic [CODE_W-1:0] w_fr_code;

    iob_keypad_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .CODE_W   (CODE_W)
    ) u_scanner (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .col_i          (col_i),
        .row_o          (row_o),
        .o_frame_done   (w_frame_done),
        .o_frame_result (w_fr_res),
        .o_frame_code   (w_fr_code)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Debounce state, candidate and frame counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cand  <= w_cand_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Debounce next-state, stepped once per completed frame
    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_cnt_nx   = r_cnt;
        w_confirm  = 1'b0;
        if (!enable) begin
            w_state_nx = ST_IDLE;
            w_cand_nx  = '0;
            w_cnt_nx   = '0;
        end else if (w_frame_done) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_fr_res == FR_KEY) begin
                        w_cand_nx = w_fr_code;
                        if (DEBOUNCE == 1) begin
                            w_confirm  = 1'b1;
                            w_state_nx = ST_PRESSED;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = ST_DEB_PRESS;
                            w_cnt_nx   = CNT_W'(1);
                        end
                    end
                end
                ST_DEB_PRESS: begin
                    if (w_fr_res != FR_KEY) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end else if (w_fr_code != r_cand) begin
                        w_cand_nx = w_fr_code;
                        w_cnt_nx  = CNT_W'(1);
                    end else if (w_cnt_inc == CNT_W'(DEBOUNCE)) begin
                        w_confirm  = 1'b1;
                        w_state_nx = ST_PRESSED;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (w_fr_res == FR_NONE) begin
                        if (DEBOUNCE == 1) begin
                            w_state_nx = ST_IDLE;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = ST_DEB_RELEASE;
                            w_cnt_nx   = CNT_W'(1);
                        end
                    end
                end
                ST_DEB_RELEASE: begin
                    if (w_fr_res != FR_NONE) begin
                        w_state_nx = ST_PRESSED;
                        w_cnt_nx   = '0;
                    end else if (w_cnt_inc == CNT_W'(DEBOUNCE)) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign w_ovr_set = w_confirm && r_valid && !key_ack;

    // Pending-code register: confirm loads, ack consumes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
        end else if (w_confirm && (!r_valid || key_ack)) begin
            r_valid <= 1'b1;
            r_code  <= w_cand_nx;
        end else if (key_ack) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr <= 1'b0;
        end else if (w_ovr_set) begin
            r_ovr <= 1'b1;
        end else if (ovr_clr) begin
            r_ovr <= 1'b0;
        end
    end

    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign overrun   = r_ovr;
    assign key_down  = (r_state == ST_PRESSED) ||
                       (r_state == ST_DEB_RELEASE);

endmodule

// File: tb/tb_iob_keypad_scan.sv
// Self-checking bench for iob_keypad_scan with a frame-level
// keypad model (4x4, SCAN_DIV=4, DEBOUNCE=3).
module tb_iob_keypad_scan;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int SDIV  = 4;
    localparam int DEB   = 3;
    localparam int FRAME = ROWS * SDIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  row_o;
    logic [3:0]  col_i;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ack;
    logic        key_down;
    logic        overrun;
    logic        ovr_clr;

    logic [15:0] keys;

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid;
    logic [3:0]  m_code;
    bit          m_ovr;
    bit          m_held;
    int          m_prev;
    int          m_run;

    always #5 clk = ~clk;

    iob_keypad_scan #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SDIV),
        .DEBOUNCE (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .row_o     (row_o),
        .col_i     (col_i),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    // Physical keypad: a closed key pulls its column low while its row is driven low
    always_comb begin
        col_i = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_o[r] && keys[r*COLS+c]) col_i[c] = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_row(input int cyc, input bit first);
        logic [3:0] one;
        one = 4'd1;
        if (first && cyc == 0) return 4'hF;
        return ~(one << (cyc / SDIV));
    endfunction

    function automatic logic [15:0] kbit(input int code);
        logic [15:0] one;
        one = 16'd1;
        return one << code;
    endfunction

    task automatic model_reset_scan();
        m_held = 1'b0;
        m_prev = -3;
        m_run  = 0;
    endtask

    // Frame-level debounce: a press counts once DEB identical single-key
    // frames in a row are seen while no key is held; a held key is let go
    // after DEB empty frames in a row.
    task automatic model_frame(input logic [15:0] k, input bit ack_l);
        int res;
        bit conf;
        if ($countones(k) == 0) res = -1;
        else if ($countones(k) > 1) res = -2;
        else begin
            res = 0;
            for (int i = 0; i < 16; i++) if (k[i]) res = i;
        end
        m_run  = (res == m_prev) ? m_run + 1 : 1;
        m_prev = res;
        conf   = 1'b0;
        if (!m_held) begin
            if (res >= 0 && m_run == DEB) begin
                conf   = 1'b1;
                m_held = 1'b1;
            end
        end else if (res == -1 && m_run == DEB) begin
            m_held = 1'b0;
        end
        if (conf) begin
            if (!m_valid || ack_l) begin
                m_valid = 1'b1;
                m_code  = res[3:0];
            end else begin
                m_ovr = 1'b1;
            end
        end else if (ack_l) begin
            m_valid = 1'b0;
        end
    endtask

    // One full frame starting at cycle 0 (called #1 after an edge)
    task automatic run_frame(input logic [15:0] k, input bit ack0,
                             input bit ack_l, input bit clr0,
                             input bit chk_rows, input bit first);
        keys = k;
        if (ack0) m_valid = 1'b0;
        if (clr0) m_ovr = 1'b0;
        for (int cyc = 0; cyc < FRAME; cyc++) begin
            key_ack = (cyc == 0 && ack0) || (cyc == FRAME - 1 && ack_l);
            ovr_clr = (cyc == 0 && clr0);
            if (chk_rows) chk("row_o", row_o, exp_row(cyc, first));
            if (cyc == FRAME - 1) begin
                chk("valid_mid", key_valid, m_valid);
                chk("ovr_mid", overrun, m_ovr);
            end
            @(posedge clk);
            #1;
        end
        key_ack = 1'b0;
        ovr_clr = 1'b0;
        model_frame(k, ack_l);
        chk("key_valid", key_valid, m_valid);
        chk("key_code", key_code, m_code);
        chk("key_down", key_down, m_held);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic frames(input logic [15:0] k, input int n, input bit ack_first);
        for (int i = 0; i < n; i++)
            run_frame(k, ack_first && i == 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] cur;
        int          r;
        rst     = 1'b1;
        enable  = 1'b0;
        key_ack = 1'b0;
        ovr_clr = 1'b0;
        keys    = '0;
        m_valid = 1'b0;
        m_code  = '0;
        m_ovr   = 1'b0;
        model_reset_scan();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_row", row_o, 4'hF);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 4'h0);
        chk("rst_down", key_down, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle scanning: row pattern over two frames
        enable = 1'b1;
        run_frame(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_frame(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Clean press of row 2 / col 1 held five frames
        frames(kbit(9), 2, 1'b0);
        chk("press_f2_valid", key_valid, 1'b0);
        frames(kbit(9), 1, 1'b0);
        chk("press_f3_valid", key_valid, 1'b1);
        chk("press_f3_code", key_code, 4'd9);
        chk("press_f3_down", key_down, 1'b1);
        frames(kbit(9), 2, 1'b0);
        chk("press_hold_ovr", overrun, 1'b0);
        frames(16'h0, 3, 1'b1);
        chk("release_down", key_down, 1'b0);

        // Bouncing press
        run_frame(kbit(9), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frames(kbit(9), 2, 1'b0);
        chk("bounce_f4_valid", key_valid, 1'b0);
        frames(kbit(9), 1, 1'b0);
        chk("bounce_valid", key_valid, 1'b1);
        chk("bounce_code", key_code, 4'd9);
        frames(16'h0, 3, 1'b1);

        // Ghosting: rows 0 and 3 together
        frames(kbit(1) | kbit(13), 4, 1'b0);
        chk("ghost_valid", key_valid, 1'b0);
        chk("ghost_down", key_down, 1'b0);
        frames(16'h0, 1, 1'b0);

        // Overrun: second press while the first is still pending
        frames(kbit(9), 3, 1'b0);
        frames(16'h0, 3, 1'b0);
        frames(kbit(6), 3, 1'b0);
        chk("ovr_code", key_code, 4'd9);
        chk("ovr_flag", overrun, 1'b1);
        run_frame(kbit(6), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_ack_valid", key_valid, 1'b0);
        run_frame(kbit(6), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovr_clr", overrun, 1'b0);

        // Confirm and ack on the same cycle
        frames(16'h0, 3, 1'b0);
        frames(kbit(9), 3, 1'b0);
        frames(16'h0, 3, 1'b0);
        frames(kbit(6), 2, 1'b0);
        run_frame(kbit(6), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("same_valid", key_valid, 1'b1);
        chk("same_code", key_code, 4'd6);
        chk("same_ovr", overrun, 1'b0);

        // Disable mid-frame with a key held and a code pending
        keys = kbit(6);
        repeat (8) @(posedge clk);
        #1;
        enable = 1'b0;
        #1;
        chk("dis_row", row_o, 4'hF);
        @(posedge clk);
        #1;
        chk("dis_down", key_down, 1'b0);
        chk("dis_valid", key_valid, 1'b1);
        chk("dis_code", key_code, 4'd6);
        repeat (5) @(posedge clk);
        #1;
        chk("dis_row2", row_o, 4'hF);
        enable = 1'b1;
        model_reset_scan();
        run_frame(16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Randomized frames against the model
        cur = 16'h0;
        repeat (60) begin
            r = $urandom_range(0, 99);
            if (r < 55) cur = cur;
            else if (r < 72) cur = 16'h0;
            else if (r < 92) cur = kbit($urandom_range(0, 15));
            else cur = kbit($urandom_range(0, 7)) | kbit($urandom_range(8, 15));
            run_frame(cur, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 4) == 0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a scan
        run_frame(16'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        frames(16'h0, 2, 1'b0);
        frames(kbit(9), 3, 1'b0);
        chk("pre_rst_valid", key_valid, 1'b1);
        keys = kbit(9);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_row", row_o, 4'hF);
        chk("arst_valid", key_valid, 1'b0);
        chk("arst_code", key_code, 4'h0);
        chk("arst_down", key_down, 1'b0);
        chk("arst_ovr", overrun, 1'b0);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
